rect_addr_gen: RTL

RECT_ADDR_GEN -- requirements
Module: rect_addr_gen

---
 rtl/rect_addr_gen_if.sv | 25 ++
 rtl/rect_addr_gen.sv | 114 +++++++++++
 2 files changed

// File: rtl/rect_addr_gen_if.sv
// Start-request, ROM-address and response-beat signals between a requester and rect_addr_gen.
// The slave modport is the generator side; the master modport is the requester/ROM side.
interface rect_addr_gen_if #(
    parameter int W_ADDR = 14,
    parameter int W_CNT  = 8
);
    logic              start_valid;
    logic              start_ready;
    logic [W_ADDR-1:0] start_base;
    logic [W_CNT-1:0]  start_count;
    logic              addr_valid;
    logic              addr_ready;
    logic [W_ADDR-1:0] addr_data;
    logic              rsp_beat;

    modport master (
        output start_valid, start_base, start_count, addr_ready, rsp_beat,
        input  start_ready, addr_valid, addr_data
    );

    modport slave (
        input  start_valid, start_base, start_count, addr_ready, rsp_beat,
        output start_ready, addr_valid, addr_data
    );
endinterface

// File: rtl/rect_addr_gen.sv
// Issues a run of consecutive ROM addresses (base + index, wrapping) while limiting
// how many addresses may be outstanding without a returned data beat.
module rect_addr_gen #(
    parameter int W_ADDR  = 14,
    parameter int W_CNT   = 8,
    parameter int MAX_OUT = 2
) (
    input  logic           clk,
    input  logic           rst,
    rect_addr_gen_if.slave bus,
    output logic           busy,
    output logic           done,
    output logic           err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    localparam logic [2:0] OUT_CAP = 3'(MAX_OUT);

    state_e            state_q, state_d;
    logic [W_ADDR-1:0] base_q, base_d;
    logic [W_CNT-1:0]  count_q, count_d;
    logic [W_CNT-1:0]  index_q, index_d;
    logic [2:0]        out_q, out_d;
    logic              err_q, err_d;

    logic start_ready;
    logic addr_valid;
    logic addr_hs;
    logic rsp_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            index_q <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            index_q <= index_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        index_d = index_q;
        out_d   = out_q;
        err_d   = err_q;

        start_ready = (state_q == IDLE);
        addr_valid  = (state_q == ISSUE) && (out_q < OUT_CAP);
        addr_hs     = addr_valid && bus.addr_ready;
        rsp_ok      = bus.rsp_beat && (out_q != '0);

        if (bus.rsp_beat && (out_q == '0)) begin
            err_d = 1'b1;
        end

        case ({addr_hs, rsp_ok})
            2'b10:   out_d = out_q + 3'd1;
            2'b01:   out_d = out_q - 3'd1;
            default: out_d = out_q;
        endcase

        if (addr_hs) begin
            index_d = index_q + W_CNT'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    base_d  = bus.start_base;
                    count_d = bus.start_count;
                    index_d = '0;
                    out_d   = '0;
                    err_d   = 1'b0;
                    state_d = (bus.start_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (addr_hs && (index_q == count_q - W_CNT'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Exit on the edge that retires the last beat, not one cycle later.
                if (out_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.start_ready = start_ready;
    assign bus.addr_valid  = addr_valid;
    assign bus.addr_data   = base_q + W_ADDR'(index_q);

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign err  = err_q;
endmodule
